// File: rtl/morse_pkg.sv
// Shared encodings for the Morse sequencer: FSM states, symbol timing and the
// per-letter symbol table.
package morse_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Symbol lengths in Morse units.
  localparam int DASH_UNITS = 3;
  localparam int DOT_UNITS  = 1;

  // One letter's stored code: symbol count (1..4) and pattern.
  // In the pattern, 1 = dash and bit 0 is the first symbol sent.
  typedef struct packed {
    logic [2:0] length;
    logic [3:0] pattern;
  } letter_t;

  // Letter table, select 0..7 = A..H.
  function automatic letter_t letter_lut(input logic [2:0] sel);
    letter_t code;
    case (sel)
      3'd0:    code = '{length: 3'd2, pattern: 4'b0010}; // A .-
      3'd1:    code = '{length: 3'd4, pattern: 4'b0001}; // B -...
      3'd2:    code = '{length: 3'd4, pattern: 4'b0101}; // C -.-.
      3'd3:    code = '{length: 3'd3, pattern: 4'b0001}; // D -..
      3'd4:    code = '{length: 3'd1, pattern: 4'b0000}; // E .
      3'd5:    code = '{length: 3'd4, pattern: 4'b0100}; // F ..-.
      3'd6:    code = '{length: 3'd3, pattern: 4'b0011}; // G --.
      default: code = '{length: 3'd4, pattern: 4'b0000}; // H ....
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_sequencer_tick_divider.sv
// Rate divider: pulses tick for one cycle every TICK_COUNT cycles, restarting
// its count from zero whenever clear is asserted.
module tick_divider #(
  parameter int TICK_COUNT = 25000000,
  parameter int TICK_W     = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_COUNT - 1);

  logic [TICK_W-1:0] count;

  // tick is combinational so the controller can act on the same edge the
  // counter wraps; it must not depend on clear (clear is derived from tick).
  assign tick = (count == LAST);

  // Free-running cycle counter with synchronous clear and wrap at LAST.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Morse letter sequencer: on start, latches the selected letter's code and
// plays it on morse_out as timed marks (dot = 1 unit, dash = 3 units)
// separated by one-unit spaces, then pulses done.
//
// Start/busy handshake: start is sampled only on edges where busy is low
// (state IDLE); a high sample launches a letter and busy rises on that same
// edge. While busy is high start is ignored (no queueing). busy falls on the
// edge that raises done, so a held start relaunches one cycle later.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_COUNT = 25000000,
  parameter int TICK_W     = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] letter,
  input  logic       start,
  output logic       morse_out,
  output logic       busy,
  output logic       done
);

  state_t     state, state_n;
  logic [3:0] pattern, pattern_n;
  logic [2:0] length, length_n;
  logic [1:0] index, index_n;
  logic [1:0] units, units_n;
  logic       morse_out_n, busy_n, done_n;
  logic       tick, clear;
  logic [1:0] unit_last;
  logic       last_symbol;
  letter_t    code;

  // Counter restarts on every state change and stays parked at 0 in IDLE.
  assign clear = (state_n != state) || (state == IDLE);

  tick_divider #(
    .TICK_COUNT (TICK_COUNT),
    .TICK_W     (TICK_W)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign code        = letter_lut(letter);
  assign unit_last   = pattern[index] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
  assign last_symbol = ({1'b0, index} == (length - 3'd1));

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    length_n  = length;
    index_n   = index;
    units_n   = units;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pattern_n = code.pattern;
          length_n  = code.length;
          index_n   = 2'd0;
          units_n   = 2'd0;
          state_n   = MARK;
        end
      end
      MARK: begin
        if (tick) begin
          if (units == unit_last) begin
            units_n = 2'd0;
            if (last_symbol) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = SPACE;
            end
          end else begin
            units_n = units + 2'd1;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          index_n = index + 2'd1;
          units_n = 2'd0;
          state_n = MARK;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    morse_out_n = (state_n == MARK);
    busy_n      = (state_n != IDLE);
  end

  // State, letter storage and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pattern   <= '0;
      length    <= '0;
      index     <= '0;
      units     <= '0;
      morse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pattern   <= pattern_n;
      length    <= length_n;
      index     <= index_n;
      units     <= units_n;
      morse_out <= morse_out_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with TICK_COUNT=4. Expected per-cycle
// {morse_out, busy, done} values are queued by hand from the letter table.
module tb_morse_sequencer;

  localparam int TICK_COUNT = 4;
  localparam int TICK_W     = 3;

  localparam logic [2:0] M = 3'b110; // mark
  localparam logic [2:0] S = 3'b010; // space
  localparam logic [2:0] D = 3'b001; // done cycle
  localparam logic [2:0] I = 3'b000; // idle

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] letter;
  logic       start;
  logic       morse_out;
  logic       busy;
  logic       done;

  logic [2:0] exp_q[$];
  int pass_count = 0;
  int total      = 0;

  // Clock and reset block.
  always #5 clock = ~clock;

  morse_sequencer #(
    .TICK_COUNT (TICK_COUNT),
    .TICK_W     (TICK_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .letter    (letter),
    .start     (start),
    .morse_out (morse_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [2:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Raise start for the edge that follows, with the given letter.
  task automatic launch(input logic [2:0] l);
    @(negedge clock);
    letter = l;
    start  = 1'b1;
    @(posedge clock);
  endtask

  // Scoreboard: compare one queued entry per cycle, driving start and letter
  // along the way; then check the busy cycle count and one idle cycle.
  task automatic run_stream(input string tag, input int poke_a, input int poke_b,
                            input int chg_at, input bit hold, input int exp_busy);
    int n;
    int c;
    int busy_seen;
    logic [2:0] e;
    n = exp_q.size();
    c = 0;
    busy_seen = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      c++;
      e = exp_q.pop_front();
      chk($sformatf("%s cyc%0d", tag, c), {29'd0, morse_out, busy, done}, {29'd0, e});
      if (busy) busy_seen++;
      start = (hold && (c < n)) || (c == poke_a) || (c == poke_b);
      if (c == chg_at) letter = 3'd0;
    end
    chk({tag, " busy_cycles"}, busy_seen, exp_busy);
    @(negedge clock);
    chk({tag, " idle_after"}, {29'd0, morse_out, busy, done}, {29'd0, I});
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    letter = 3'd0;
    repeat (2) @(negedge clock);
    chk("reset_state", {29'd0, morse_out, busy, done}, {29'd0, I});
    reset = 1'b0;
    @(negedge clock);
    chk("idle_no_start", {29'd0, morse_out, busy, done}, {29'd0, I});

    // E: single dot.
    push(M, 4); push(D, 1);
    launch(3'd4);
    run_stream("E", 0, 0, 0, 1'b0, 4);

    // A: dot, space, dash.
    push(M, 4); push(S, 4); push(M, 12); push(D, 1);
    launch(3'd0);
    run_stream("A", 0, 0, 0, 1'b0, 20);

    // H: four dots; letter switched to A mid-sequence.
    push(M, 4); push(S, 4); push(M, 4); push(S, 4);
    push(M, 4); push(S, 4); push(M, 4); push(D, 1);
    launch(3'd7);
    run_stream("H", 0, 0, 6, 1'b0, 28);

    // D: dash, dot, dot; start re-pulsed while busy.
    push(M, 12); push(S, 4); push(M, 4); push(S, 4); push(M, 4); push(D, 1);
    launch(3'd3);
    run_stream("D", 5, 15, 0, 1'b0, 28);

    // Held start with E: 1-cycle gap, done every 5 cycles.
    push(M, 4); push(D, 1); push(M, 4); push(D, 1); push(M, 4); push(D, 1);
    launch(3'd4);
    run_stream("E_held", 0, 0, 0, 1'b1, 12);

    // B with asynchronous reset in the middle of the leading dash.
    launch(3'd1);
    repeat (6) @(negedge clock) start = 1'b0;
    chk("B_mid_mark", {29'd0, morse_out, busy, done}, {29'd0, M});
    #2 reset = 1'b1;
    #1 chk("async_reset", {29'd0, morse_out, busy, done}, {29'd0, I});
    #1 reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk($sformatf("post_reset cyc%0d", k), {29'd0, morse_out, busy, done}, {29'd0, I});
    end

    $display("%0d/%0d checks passed", pass_count, total);
    $finish;
  end

endmodule
